fuel_dispense_controller: RTL and testbench

FUEL_DISPENSE_CONTROLLER -- requirements
Module: fuel_dispense_controller

---
 rtl/fuel_pump_pkg.sv | 21 ++
 rtl/pulse_sync.sv | 30 +++
 rtl/fuel_dispense_controller.sv | 124 ++++++++++++
 tb/tb_fuel_dispense_controller.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/fuel_pump_pkg.sv
// Shared types and constants for the fuel dispenser: FSM state encoding,
// default meter resolution and the liter ceiling.
`timescale 1ns/1ps
package fuel_pump_pkg;

  localparam int unsigned DEFAULT_PULSES_PER_LITER = 10;
  localparam logic [7:0]  MAX_LITERS               = 8'd255;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    ARMED      = 2'd1,
    DISPENSING = 2'd2,
    FINISH     = 2'd3
  } state_e;

  // A preset of zero means "no preset", i.e. dispense up to the ceiling.
  function automatic logic [7:0] effective_limit(input logic [7:0] preset);
    return (preset == 8'd0) ? MAX_LITERS : preset;
  endfunction

endpackage

// File: rtl/pulse_sync.sv
// Two-flop synchronizer for the flow-meter input followed by a rising-edge
// detector; rise is high for exactly one clk cycle per synchronized rise.
`timescale 1ns/1ps
module pulse_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic async_in,
  output logic rise
);

  logic meta_q;
  logic sync_q;
  logic prev_q;

  // Synchronizer chain plus one delay stage for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      meta_q <= async_in;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign rise = sync_q & ~prev_q;

endmodule

// File: rtl/fuel_dispense_controller.sv
// Fuel dispense controller: sale FSM, latched liter limit, per-liter pulse
// sub-counter and the whole-liter fuel_amount counter.
`timescale 1ns/1ps
module fuel_dispense_controller
  import fuel_pump_pkg::*;
#(
  parameter int unsigned PULSES_PER_LITER = DEFAULT_PULSES_PER_LITER
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       stop,
  input  logic       nozzle_in,
  input  logic       flow_pulse,
  input  logic [7:0] preset_liters,
  output logic [7:0] fuel_amount,
  output logic       pump_on,
  output logic       busy,
  output logic       done
);

  localparam logic [7:0] SUB_LAST = 8'(PULSES_PER_LITER - 1);

  state_e     state_q, state_d;
  logic [7:0] fuel_q, fuel_d;
  logic [7:0] sub_q, sub_d;
  logic [7:0] limit_q, limit_d;
  logic       pump_on_q, busy_q, done_q;
  logic       rise_s;

  pulse_sync u_pulse_sync (
    .clk      (clk),
    .rst_n    (rst_n),
    .async_in (flow_pulse),
    .rise     (rise_s)
  );

  // Next-state and counter update logic.
  always_comb begin
    state_d = state_q;
    fuel_d  = fuel_q;
    sub_d   = sub_q;
    limit_d = limit_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = ARMED;
          fuel_d  = 8'd0;
          sub_d   = 8'd0;
          limit_d = effective_limit(preset_liters);
        end else begin
          state_d = IDLE;
        end
      end
      ARMED: begin
        if (stop) begin
          state_d = IDLE;
        end else if (nozzle_in) begin
          state_d = DISPENSING;
        end else begin
          state_d = ARMED;
        end
      end
      DISPENSING: begin
        if (rise_s) begin
          if (sub_q >= SUB_LAST) begin
            sub_d = 8'd0;
            // Guard keeps the count at or below the limit even if it were reached.
            if (fuel_q < limit_q) begin
              fuel_d = fuel_q + 8'd1;
            end else begin
              fuel_d = fuel_q;
            end
          end else begin
            sub_d = sub_q + 8'd1;
          end
        end else begin
          sub_d = sub_q;
        end
        // Using fuel_d lets a liter completed this cycle end the sale at once.
        if ((fuel_d == limit_q) || stop || !nozzle_in) begin
          state_d = FINISH;
        end else begin
          state_d = DISPENSING;
        end
      end
      FINISH: begin
        state_d = IDLE;
        sub_d   = 8'd0;
      end
      default: begin
        state_d = IDLE;
        sub_d   = 8'd0;
      end
    endcase
  end

  // State, counters and registered outputs derived from the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      fuel_q    <= 8'd0;
      sub_q     <= 8'd0;
      limit_q   <= MAX_LITERS;
      pump_on_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      fuel_q    <= fuel_d;
      sub_q     <= sub_d;
      limit_q   <= limit_d;
      pump_on_q <= (state_d == DISPENSING);
      busy_q    <= (state_d != IDLE);
      done_q    <= (state_d == FINISH);
    end
  end

  assign fuel_amount = fuel_q;
  assign pump_on     = pump_on_q;
  assign busy        = busy_q;
  assign done        = done_q;

endmodule

// File: tb/tb_fuel_dispense_controller.sv
// Directed bench for fuel_dispense_controller: sales push their expected
// final liter count; a monitor pops and compares on every done pulse.
`timescale 1ns/1ps
module tb_fuel_dispense_controller;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       stop;
  logic       nozzle_in;
  logic       flow_pulse;
  logic [7:0] preset_liters;
  logic [7:0] fuel_amount;
  logic       pump_on;
  logic       busy;
  logic       done;

  int n_vec;
  int n_err;
  int exp_q[$];

  fuel_dispense_controller #(.PULSES_PER_LITER(10)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .stop          (stop),
    .nozzle_in     (nozzle_in),
    .flow_pulse    (flow_pulse),
    .preset_liters (preset_liters),
    .fuel_amount   (fuel_amount),
    .pump_on       (pump_on),
    .busy          (busy),
    .done          (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor: each done pulse must match a queued sale result.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && done === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_done: got done=1 with fuel_amount=%0d, expected no done", fuel_amount);
      end else begin
        chk("done_fuel_amount", int'(fuel_amount), exp_q.pop_front());
        chk("done_pump_off", int'(pump_on), 0);
      end
    end
  end

  task automatic send_pulse();
    @(negedge clk) flow_pulse = 1'b1;
    repeat (3) @(negedge clk);
    flow_pulse = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic send_pulses(input int n);
    for (int i = 0; i < n; i++) send_pulse();
  endtask

  task automatic begin_sale(input logic [7:0] preset, input logic nozzle);
    @(negedge clk);
    preset_liters = preset;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    nozzle_in = nozzle;
  endtask

  task automatic wait_idle(input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (busy === 1'b0) break;
    end
    chk("wait_idle_timeout", int'(busy), 0);
  endtask

  initial begin
    int pump_seen;
    clk = 1'b0;
    rst_n = 1'b0;
    start = 1'b0;
    stop = 1'b0;
    nozzle_in = 1'b0;
    flow_pulse = 1'b0;
    preset_liters = 8'd0;
    n_vec = 0;
    n_err = 0;

    // Reset state.
    repeat (3) @(negedge clk);
    chk("rst_fuel", int'(fuel_amount), 0);
    chk("rst_pump", int'(pump_on), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Preset 3: 30 pulses give 1,2,3 liters, then pulses are ignored.
    exp_q.push_back(3);
    begin_sale(8'd3, 1'b1);
    @(negedge clk);
    chk("a_pump_on", int'(pump_on), 1);
    chk("a_busy", int'(busy), 1);
    for (int i = 1; i <= 30; i++) begin
      send_pulse();
      if (i % 10 == 0) chk("a_liters", int'(fuel_amount), i / 10);
      if (i == 10 || i == 20) chk("a_pump_mid", int'(pump_on), 1);
    end
    chk("a_pump_after_30", int'(pump_on), 0);
    chk("a_busy_after_30", int'(busy), 0);
    send_pulses(5);
    chk("a_ignored_31_35", int'(fuel_amount), 3);
    nozzle_in = 1'b0;

    // No preset: saturates at 255.
    exp_q.push_back(255);
    begin_sale(8'd0, 1'b1);
    send_pulses(2600);
    chk("b_saturate", int'(fuel_amount), 255);
    chk("b_pump_off", int'(pump_on), 0);
    chk("b_idle", int'(busy), 0);
    nozzle_in = 1'b0;

    // Preset 10, 25 pulses then nozzle down.
    exp_q.push_back(2);
    begin_sale(8'd10, 1'b1);
    send_pulses(25);
    chk("c_before_drop", int'(fuel_amount), 2);
    @(negedge clk) nozzle_in = 1'b0;
    wait_idle(10);
    chk("c_final", int'(fuel_amount), 2);

    // Stop coincident with the tenth pulse's counter update.
    exp_q.push_back(1);
    begin_sale(8'd0, 1'b1);
    send_pulses(9);
    chk("d_nine_pulses", int'(fuel_amount), 0);
    @(negedge clk) flow_pulse = 1'b1;
    @(negedge clk);
    @(negedge clk) stop = 1'b1;
    @(negedge clk);
    chk("d_done_next_cycle", int'(done), 1);
    chk("d_fuel_one", int'(fuel_amount), 1);
    stop = 1'b0;
    flow_pulse = 1'b0;
    nozzle_in = 1'b0;
    repeat (3) @(negedge clk);

    // Start with nozzle down, abort from ARMED.
    begin_sale(8'd5, 1'b0);
    pump_seen = 0;
    @(negedge clk);
    chk("e_armed_busy", int'(busy), 1);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    chk("e_back_idle", int'(busy), 0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (pump_on !== 1'b0) pump_seen++;
    end
    chk("e_pump_never", pump_seen, 0);
    chk("e_fuel_cleared", int'(fuel_amount), 0);

    // Reset mid-dispense after 15 pulses.
    begin_sale(8'd0, 1'b1);
    send_pulses(15);
    chk("f_fuel_before_rst", int'(fuel_amount), 1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("f_rst_pump_async", int'(pump_on), 0);
    chk("f_rst_fuel_async", int'(fuel_amount), 0);
    chk("f_rst_done", int'(done), 0);
    @(negedge clk) rst_n = 1'b1;
    exp_q.push_back(1);
    begin_sale(8'd0, 1'b1);
    send_pulses(10);
    chk("f_recount", int'(fuel_amount), 1);
    @(negedge clk) stop = 1'b1;
    @(negedge clk) stop = 1'b0;
    nozzle_in = 1'b0;
    wait_idle(10);

    repeat (5) @(negedge clk);
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
